rdn_weight_mem: RTL
===================

# rdn_weight_mem

Line-oriented weight memory responder serving the rotation-detection network's weight loader. A host-side port streams 16-bit weight words into a ping-pong bank of 32-word lines. The block answers the loader's `req_mem` request with a single-cycle `mem_ready` pulse and a full 32×16-bit `mem_data` line. It is the responder end of the `req_mem`/`mem_ready`/`mem_data` interface driven by the RDN weight loader.

## Interface
- `NUM_LINES`, 2: line buffers in the ring; power of two, ≥2.
- `RESP_LAT`, 2: cycles from accepted request to `mem_ready`; ≥1.
- `clk` input 1: clock, all state on rising edge.
- `rst_n` input 1: reset. One clock; reset is asynchronous and active-low.
- `flush` input 1: synchronous clear of buffers, pointers and FSM; `lines_served` and checksum are kept.
- `host_wr_en` input 1: host word valid.
- `host_wr_data` input 16: host weight word.
- `host_wr_ready` output 1: a word is accepted when `host_wr_en & host_wr_ready`.
- `req_mem` input 1: loader request, level-sensitive.
- `mem_ready` output 1: one-cycle pulse, `mem_data` is valid.
- `mem_data` output [15:0] ×32: delivered line; word k is the k-th word written into that line.
- `lines_served` output 10: count of delivered lines, wraps.
- `chk_sum` output 16: running checksum (see Configuration).

## Operation
- **Write side**
  - `wr_line` and `wr_word` (0..31) are set by reset/flush to 0.
  - An accepted word is stored at `buf[wr_line][wr_word]`, and `wr_word` increments.
  - On acceptance of word 31: the line is marked full, `full_cnt` increments, `wr_line` advances modulo `NUM_LINES`, and `wr_word` returns to 0.
  - `host_wr_ready = (full_cnt < NUM_LINES)`, decoded from registered state.
- **Read FSM:** IDLE → WAIT → RESP → GAP → IDLE.
  - **IDLE:** if `req_mem && full_cnt != 0`, go to WAIT and load `lat_cnt = RESP_LAT-1`. If `RESP_LAT == 1`, go directly to RESP.
  - **WAIT:** decrement `lat_cnt`; go to RESP when it reaches 0. The request is committed, so dropping `req_mem` in WAIT does not cancel it.
  - **RESP:**
    - `mem_ready = 1`; the `mem_data` register holds `buf[rd_line]`, loaded on entry.
    - At the end of the cycle: the line is freed, `full_cnt` decrements, `rd_line` advances modulo `NUM_LINES`, and `lines_served` increments.
  - **GAP:** one idle cycle with `mem_ready = 0`, then IDLE. `req_mem` is re-sampled in IDLE, so a level held high yields back-to-back responses spaced `RESP_LAT+2` cycles apart.
- **`mem_data`** holds the last delivered line until the next RESP entry. It is never cleared by flush.
- **Simultaneous completion and free:** if a host completes a line in the same cycle a line is freed, `full_cnt` is unchanged and both pointers advance.
- **`req_mem` with no full line:** stay in IDLE; there is no response and no error.
- **`flush`** has priority over all other activity in the same cycle. A response in WAIT is abandoned; `mem_ready` stays 0.

## Timing
- **Reset values:** `mem_ready = 0`, `mem_data` all 0, `host_wr_ready = 1`, `lines_served = 0`, `chk_sum = 0`. FSM = IDLE, pointers 0, `full_cnt = 0`.
- **Request latency:** `req_mem` sampled high in IDLE at edge t with a full line present gives `mem_ready` high during cycle t+`RESP_LAT`.
- **Line visibility:** a line completed at edge t is visible to IDLE at edge t+1.
- **Counter updates:** `lines_served` updates at the edge ending RESP and is visible the cycle after the pulse.
- **Outputs:** all outputs are registered except `host_wr_ready`, which is combinational from registered state only.

## Configuration
- **`RDN_WEIGHT_MEM_CHKSUM_EN`**
  - Defined: `chk_sum` accumulates, modulo 2^16, the sum of all 32 words of each delivered line. It updates at the edge ending RESP and is unaffected by flush.
  - Undefined: the accumulator logic is absent and `chk_sum` is tied to 0.

## Test plan
- **Single line:** after reset, write words 0x0000..0x001F, then hold `req_mem` → `mem_ready` pulses once 2 cycles after the sample with `mem_data[k] = k`; `lines_served = 1`. With the macro, `chk_sum = 0x01F0`.
- **Full / backpressure:** write 64 words with no request → `host_wr_ready = 0` after word 63. Word 64 is not accepted until one RESP completes, and `host_wr_ready` returns to 1 in the cycle after RESP.
- **Back-to-back:** 2 full lines, `req_mem` held high → two pulses 4 cycles apart (`RESP_LAT = 2`), delivering line 0 then line 1. A third request gives no pulse.
- **Request drop:** `req_mem` high for one cycle, then low → the response is still delivered `RESP_LAT` cycles later.
- **Flush in WAIT:** assert `flush` during WAIT → no `mem_ready`, `full_cnt = 0`, `host_wr_ready = 1`. `lines_served` and `mem_data` are unchanged.
- **Simultaneous:** the host writes word 31 of line 1 in the same cycle RESP frees line 0 → `full_cnt` stays 1, the next request delivers line 1, and the write pointer has wrapped to line 0.

Source files
------------

// File: rtl/rdn_weight_mem.sv
// Ping-pong line buffer that answers the RDN weight loader's req_mem with a full 32-word line.
// Optional RDN_WEIGHT_MEM_CHKSUM_EN adds a running 16-bit sum of every delivered line on chk_sum.
module rdn_weight_mem #(
    parameter int NUM_LINES = 2,
    parameter int RESP_LAT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              host_wr_en,
    input  logic [15:0]       host_wr_data,
    output logic              host_wr_ready,
    input  logic              req_mem,
    output logic              mem_ready,
    output logic [31:0][15:0] mem_data,
    output logic [9:0]        lines_served,
    output logic [15:0]       chk_sum
);

    localparam int LW = $clog2(NUM_LINES);
    localparam int CW = $clog2(NUM_LINES + 1);
    localparam int TW = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_GAP} state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     lat_q, lat_d;
    logic [LW-1:0]     wr_line_q, rd_line_q;
    logic [4:0]        wr_word_q;
    logic [CW-1:0]     full_cnt_q, full_cnt_d;
    logic              mem_ready_q;
    logic [31:0][15:0] mem_data_q;
    logic [9:0]        lines_served_q;
    logic [15:0]       line_mem_q [NUM_LINES][32];

    logic wr_acc, line_done, line_free, load_resp;

    assign host_wr_ready = (full_cnt_q < CW'(NUM_LINES));
    assign wr_acc        = host_wr_en & host_wr_ready & ~flush;
    assign line_done     = wr_acc & (wr_word_q == 5'd31);
    assign line_free     = (state_q == S_RESP) & ~flush;

    // A line completing in the same cycle one is freed leaves the count unchanged.
    always_comb begin
        full_cnt_d = full_cnt_q;
        if (flush)
            full_cnt_d = '0;
        else if (line_done && !line_free)
            full_cnt_d = full_cnt_q + CW'(1);
        else if (!line_done && line_free)
            full_cnt_d = full_cnt_q - CW'(1);
    end

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        load_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_mem && full_cnt_q != '0) begin
                    if (RESP_LAT == 1) begin
                        state_d   = S_RESP;
                        load_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        lat_d   = TW'(RESP_LAT - 1);
                    end
                end
            end
            S_WAIT: begin
                lat_d = lat_q - TW'(1);
                if (lat_q == TW'(1)) begin
                    state_d   = S_RESP;
                    load_resp = 1'b1;
                end
            end
            S_RESP:  state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d   = S_IDLE;
            lat_d     = '0;
            load_resp = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            lat_q          <= '0;
            wr_line_q      <= '0;
            wr_word_q      <= '0;
            rd_line_q      <= '0;
            full_cnt_q     <= '0;
            mem_ready_q    <= 1'b0;
            mem_data_q     <= '0;
            lines_served_q <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            full_cnt_q  <= full_cnt_d;
            mem_ready_q <= load_resp;
            if (load_resp) begin
                for (int k = 0; k < 32; k++)
                    mem_data_q[k] <= line_mem_q[rd_line_q][k];
            end
            if (flush) begin
                wr_line_q <= '0;
                wr_word_q <= '0;
                rd_line_q <= '0;
            end else begin
                if (wr_acc) begin
                    if (line_done) begin
                        wr_word_q <= '0;
                        wr_line_q <= wr_line_q + LW'(1);
                    end else begin
                        wr_word_q <= wr_word_q + 5'd1;
                    end
                end
                if (line_free) begin
                    rd_line_q      <= rd_line_q + LW'(1);
                    lines_served_q <= lines_served_q + 10'd1;
                end
            end
        end
    end

    // Line storage carries no reset; validity is tracked solely by full_cnt and the pointers.
    always_ff @(posedge clk) begin
        if (wr_acc)
            line_mem_q[wr_line_q][wr_word_q] <= host_wr_data;
    end

`ifdef RDN_WEIGHT_MEM_CHKSUM_EN
    logic [15:0] chk_q;
    logic [15:0] line_sum;

    always_comb begin
        line_sum = '0;
        for (int k = 0; k < 32; k++)
            line_sum = line_sum + mem_data_q[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            chk_q <= '0;
        else if (line_free)
            chk_q <= chk_q + line_sum;
    end

    assign chk_sum = chk_q;
`else
    assign chk_sum = '0;
`endif

    assign mem_ready    = mem_ready_q;
    assign mem_data     = mem_data_q;
    assign lines_served = lines_served_q;

endmodule
